// File: rtl/dmem_arbiter.sv
// Two-master arbiter/sequencer for the shared data-memory port.
// Master 0 = instruction fetch, master 1 = load/store. One transaction at a time.
module dmem_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req_valid,
  output logic          m0_req_ready,
  input  logic [AW-1:0] m0_addr,
  input  logic          m0_we,
  input  logic [DW-1:0] m0_wdata,
  input  logic [2:0]    m0_ctr,
  output logic          m0_resp_valid,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_resp_err,
  input  logic          m1_req_valid,
  output logic          m1_req_ready,
  input  logic [AW-1:0] m1_addr,
  input  logic          m1_we,
  input  logic [DW-1:0] m1_wdata,
  input  logic [2:0]    m1_ctr,
  output logic          m1_resp_valid,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_resp_err,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  output logic [2:0]    mem_ctr,
  input  logic          mem_resp_valid,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state;
  logic            rr_ptr;
  logic            owner;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   rdata_q;
  logic            err_q;

  logic            any_c;
  logic            win_c;
  logic            accept_c;
  logic [AW-1:0]   sel_addr_c;
  logic            sel_we_c;
  logic [DW-1:0]   sel_wdata_c;
  logic [2:0]      sel_ctr_c;
  logic            sel_legal_c;

  // Grant selection: a lone requester wins, ties go to the round-robin pointer
  assign any_c       = m0_req_valid | m1_req_valid;
  assign win_c       = (m0_req_valid & m1_req_valid) ? rr_ptr : m1_req_valid;
  assign accept_c    = (state == IDLE) & any_c;

  assign sel_addr_c  = win_c ? m1_addr  : m0_addr;
  assign sel_we_c    = win_c ? m1_we    : m0_we;
  assign sel_wdata_c = win_c ? m1_wdata : m0_wdata;
  assign sel_ctr_c   = win_c ? m1_ctr   : m0_ctr;

  // Only the five defined access sizes reach memory
  always_comb begin
    sel_legal_c = 1'b0;
    case (sel_ctr_c)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: sel_legal_c = 1'b1;
      default:                                sel_legal_c = 1'b0;
    endcase
  end

  // Ready is gated by reset so every output reads zero while rst is high
  assign m0_req_ready  = ~rst & accept_c & ~win_c;
  assign m1_req_ready  = ~rst & accept_c &  win_c;

  assign mem_req_valid = (state == ISSUE);

  assign m0_resp_valid = (state == RESP) & ~owner;
  assign m1_resp_valid = (state == RESP) &  owner;
  assign m0_rdata      = m0_resp_valid ? rdata_q : '0;
  assign m1_rdata      = m1_resp_valid ? rdata_q : '0;
  assign m0_resp_err   = m0_resp_valid & err_q;
  assign m1_resp_err   = m1_resp_valid & err_q;

  // Transaction sequencer: accept, issue, wait with timeout, respond
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      owner     <= 1'b0;
      cnt       <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      mem_ctr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_c) begin
            owner     <= win_c;
            mem_addr  <= sel_addr_c;
            mem_we    <= sel_we_c;
            mem_wdata <= sel_wdata_c;
            mem_ctr   <= sel_ctr_c;
            if (sel_legal_c) begin
              state <= ISSUE;
            end else begin
              rdata_q <= '0;
              err_q   <= 1'b1;
              state   <= RESP;
            end
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            cnt   <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt + CW'(1);
          if (mem_resp_valid) begin
            rdata_q <= mem_rdata;
            err_q   <= 1'b0;
            state   <= RESP;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state   <= RESP;
          end
        end
        RESP: begin
          rr_ptr <= ~owner;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by random
// transactions, checked against a transaction-level reference model.
module tb_dmem_arbiter;

  localparam int unsigned T  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk;
  logic          rst;
  logic          m0_req_valid, m1_req_valid;
  logic          m0_req_ready, m1_req_ready;
  logic [AW-1:0] m0_addr, m1_addr;
  logic          m0_we, m1_we;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic [2:0]    m0_ctr, m1_ctr;
  logic          m0_resp_valid, m1_resp_valid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          m0_resp_err, m1_resp_err;
  logic          mem_req_valid, mem_req_ready;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [2:0]    mem_ctr;
  logic          mem_resp_valid;
  logic [DW-1:0] mem_rdata;

  dmem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_addr(m0_addr),
    .m0_we(m0_we), .m0_wdata(m0_wdata), .m0_ctr(m0_ctr),
    .m0_resp_valid(m0_resp_valid), .m0_rdata(m0_rdata), .m0_resp_err(m0_resp_err),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_addr(m1_addr),
    .m1_we(m1_we), .m1_wdata(m1_wdata), .m1_ctr(m1_ctr),
    .m1_resp_valid(m1_resp_valid), .m1_rdata(m1_rdata), .m1_resp_err(m1_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_ctr(mem_ctr),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  // Reference state: pending request per master and the tie-break preference
  bit          pend [2];
  logic [31:0] q_addr [2];
  logic        q_we [2];
  logic [31:0] q_wdata [2];
  logic [2:0]  q_ctr [2];
  int          pref;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit ctr_ok(input logic [2:0] c);
    return (c == 3'b000) || (c == 3'b001) || (c == 3'b010) || (c == 3'b100) || (c == 3'b101);
  endfunction

  task automatic set_req(input int m, input logic [31:0] a, input logic we,
                         input logic [31:0] wd, input logic [2:0] c);
    pend[m]    = 1'b1;
    q_addr[m]  = a;
    q_we[m]    = we;
    q_wdata[m] = wd;
    q_ctr[m]   = c;
  endtask

  task automatic drive_masters();
    m0_req_valid = pend[0];
    m0_addr      = q_addr[0];
    m0_we        = q_we[0];
    m0_wdata     = q_wdata[0];
    m0_ctr       = q_ctr[0];
    m1_req_valid = pend[1];
    m1_addr      = q_addr[1];
    m1_we        = q_we[1];
    m1_wdata     = q_wdata[1];
    m1_ctr       = q_ctr[1];
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, 64'(|{m0_req_ready, m1_req_ready, m0_resp_valid, m1_resp_valid,
                   m0_rdata, m1_rdata, m0_resp_err, m1_resp_err, mem_req_valid,
                   mem_addr, mem_we, mem_wdata, mem_ctr}), 64'(0));
  endtask

  // One transaction: d = extra cycles memory holds ready low, r = WAIT cycle
  // of the memory response (values above T+1 mean it never responds).
  // Called and returning at posedge+1 with the arbiter idle.
  task automatic run_txn(input int d, input int r, input logic [31:0] rd,
                         input bit stale, input int rst_at);
    int w, p, rw;
    bit legal, eerr;
    logic [31:0] erd;
    w     = (pend[0] && pend[1]) ? pref : (pend[1] ? 1 : 0);
    legal = ctr_ok(q_ctr[w]);
    rw    = (r < int'(T)) ? r : int'(T);
    p     = legal ? 2 + d + rw : 1;
    eerr  = !legal || (r > int'(T));
    erd   = eerr ? 32'h0 : rd;
    for (int c = 0; c <= p; c++) begin
      drive_masters();
      mem_req_ready  = legal && (c == 1 + d);
      mem_resp_valid = (legal && r <= int'(T) + 1 && c == 1 + d + r) || (stale && c == 0);
      mem_rdata      = (legal && c == 1 + d + r) ? rd : $urandom;
      #1;
      chk("m0_req_ready", 64'(m0_req_ready), 64'(c == 0 && w == 0));
      chk("m1_req_ready", 64'(m1_req_ready), 64'(c == 0 && w == 1));
      chk("mem_req_valid", 64'(mem_req_valid), 64'(legal && c >= 1 && c <= 1 + d));
      if (legal && c >= 1 && c <= 1 + d) begin
        chk("mem_addr",  64'(mem_addr),  64'(q_addr[w]));
        chk("mem_we",    64'(mem_we),    64'(q_we[w]));
        chk("mem_wdata", 64'(mem_wdata), 64'(q_wdata[w]));
        chk("mem_ctr",   64'(mem_ctr),   64'(q_ctr[w]));
      end
      chk("m0_resp_valid", 64'(m0_resp_valid), 64'(c == p && w == 0));
      chk("m1_resp_valid", 64'(m1_resp_valid), 64'(c == p && w == 1));
      if (c == p) begin
        chk("resp_rdata", 64'(w == 1 ? m1_rdata : m0_rdata), 64'(erd));
        chk("resp_err",   64'(w == 1 ? m1_resp_err : m0_resp_err), 64'(eerr));
      end
      if (c == 0) pend[w] = 1'b0;
      if (c == rst_at) begin
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst_outs");
        @(posedge clk);
        #1;
        chk_all_zero("held_rst_outs");
        rst            = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        pref           = 0;
        return;
      end
      @(posedge clk);
      #1;
    end
    pref = (w == 0) ? 1 : 0;
  endtask

  // Cycles with no master requests; a stray memory response must be ignored
  task automatic idle_cycles(input int n, input bit stray);
    for (int c = 0; c < n; c++) begin
      drive_masters();
      mem_req_ready  = 1'b0;
      mem_resp_valid = stray;
      mem_rdata      = $urandom;
      #1;
      chk("idle_m0_resp", 64'(m0_resp_valid), 64'(0));
      chk("idle_m1_resp", 64'(m1_resp_valid), 64'(0));
      chk("idle_mem_req", 64'(mem_req_valid), 64'(0));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    pref  = 0;
    for (int m = 0; m < 2; m++) begin
      pend[m] = 1'b0; q_addr[m] = '0; q_we[m] = 1'b0; q_wdata[m] = '0; q_ctr[m] = '0;
    end
    rst = 1'b1;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
    drive_masters();

    // Reset state
    @(posedge clk); #1;
    chk_all_zero("reset_outs");
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycles(1, 1'b0);

    // Single read from master 1
    set_req(1, 32'h8000_0100, 1'b0, 32'h0, 3'b010);
    run_txn(0, 1, 32'hDEAD_BEEF, 1'b0, -1);

    // Contention: both masters keep requesting, grants must alternate
    for (int i = 0; i < 4; i++) begin
      for (int m = 0; m < 2; m++)
        if (!pend[m]) set_req(m, 32'h1000_0000 + 32'(m * 256 + i * 4), 1'b0, 32'h0, 3'b010);
      run_txn(0, 1, $urandom, 1'b0, -1);
    end
    pend[0] = 1'b0; pend[1] = 1'b0;
    idle_cycles(1, 1'b0);

    // Backpressure: memory holds ready low for 5 cycles
    set_req(0, 32'h2000_0040, 1'b1, 32'hCAFE_F00D, 3'b101);
    run_txn(5, 2, $urandom, 1'b0, -1);

    // Timeout: memory never responds, then a late response while idle
    set_req(1, 32'h3000_0008, 1'b0, 32'h0, 3'b010);
    run_txn(0, 99, $urandom, 1'b0, -1);
    idle_cycles(2, 1'b1);
    idle_cycles(1, 1'b0);

    // Response coinciding with the timeout cycle wins
    set_req(1, 32'h3000_000C, 1'b0, 32'h0, 3'b000);
    run_txn(1, int'(T), 32'h1234_5678, 1'b0, -1);

    // Illegal access size from master 0 leaves preference on master 1
    set_req(0, 32'h4000_0000, 1'b0, 32'h0, 3'b111);
    run_txn(0, 1, $urandom, 1'b0, -1);

    // Reset during WAIT of a master-1 transaction, then master 0 wins the tie
    set_req(0, 32'h5000_0000, 1'b0, 32'h0, 3'b010);
    set_req(1, 32'h5000_0100, 1'b0, 32'h0, 3'b010);
    run_txn(1, 3, $urandom, 1'b0, 3);
    set_req(0, 32'h5000_0004, 1'b0, 32'h0, 3'b010);
    set_req(1, 32'h5000_0104, 1'b0, 32'h0, 3'b010);
    run_txn(0, 1, 32'hA5A5_5A5A, 1'b1, -1);

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      for (int m = 0; m < 2; m++)
        if (!pend[m] && ($urandom % 2 == 0))
          set_req(m, $urandom, 1'($urandom % 2), $urandom, 3'($urandom % 8));
      if (!pend[0] && !pend[1])
        set_req(int'($urandom % 2), $urandom, 1'($urandom % 2), $urandom, 3'($urandom % 8));
      run_txn(int'($urandom % 4), 1 + int'($urandom % (T + 1)), $urandom, 1'($urandom % 4 == 0), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
